alarm_controller: RTL

ALARM_CONTROLLER -- requirements
Module: alarm_controller

---
 rtl/alarm_controller.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alarm_controller.sv
// Alarm clock controller: arms on enable, rings on a fresh time match, and handles
// snooze, stop and ring timeout. All outputs are registered.
module alarm_controller #(
  parameter int unsigned SNOOZE_MINUTES   = 9,
  parameter int unsigned RING_TIMEOUT_SEC = 600,
  parameter int unsigned MAX_SNOOZES      = 3
)(
  input  logic        i_Clk_5MHz,
  input  logic        i_Reset,
  input  logic        i_Sec_Tick,
  input  logic [15:0] i_Current_Time,
  input  logic        i_Current_PM,
  input  logic [15:0] i_Alarm_Time,
  input  logic        i_Alarm_PM,
  input  logic        i_Alarm_Enable,
  input  logic        i_Set_Mode,
  input  logic        i_Snooze,
  input  logic        i_Stop,
  output logic [1:0]  o_State,
  output logic        o_Buzzer,
  output logic [2:0]  o_Snooze_Count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_e;

  localparam logic [11:0] RING_LAST = 12'(RING_TIMEOUT_SEC - 1);
  localparam logic [9:0]  SNZ_LOAD  = 10'(SNOOZE_MINUTES * 60);
  localparam logic [2:0]  MAX_SNZ   = 3'(MAX_SNOOZES);

  state_e      state_q, state_d;
  logic [11:0] ring_q, ring_d;
  logic [9:0]  snz_q, snz_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic        buz_q;
  logic        match, match_q, trigger;

  // Edge-detect the match so a whole matching minute fires only once.
  assign match   = ({i_Current_PM, i_Current_Time} == {i_Alarm_PM, i_Alarm_Time});
  assign trigger = match & ~match_q & ~i_Set_Mode;

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!i_Alarm_Enable) begin
      state_d = IDLE;
      ring_d  = '0;
      snz_d   = '0;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (trigger) begin
            state_d = RINGING;
            ring_d  = '0;
            cnt_d   = '0;
            phase_d = 1'b1;
          end
        end
        RINGING: begin
          if (i_Stop) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else if (i_Snooze && (cnt_q < MAX_SNZ)) begin
            state_d = SNOOZE;
            cnt_d   = cnt_q + 3'd1;
            snz_d   = SNZ_LOAD;
          end else if (i_Snooze) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else if (i_Sec_Tick) begin
            if (ring_q == RING_LAST) begin
              state_d = ARMED;
              cnt_d   = '0;
            end else begin
              ring_d  = ring_q + 12'd1;
              phase_d = ~phase_q;
            end
          end
        end
        SNOOZE: begin
          if (i_Stop) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else if (i_Sec_Tick) begin
            snz_d = snz_q - 10'd1;
            if (snz_q == 10'd1) begin
              state_d = RINGING;
              ring_d  = '0;
              phase_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk_5MHz) begin
    if (i_Reset) begin
      state_q <= IDLE;
      ring_q  <= '0;
      snz_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      buz_q   <= 1'b0;
      match_q <= 1'b1;  // a match held across reset release must not ring
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      buz_q   <= (state_d == RINGING) & phase_d;
      match_q <= match;
    end
  end

  assign o_State        = state_q;
  assign o_Buzzer       = buz_q;
  assign o_Snooze_Count = cnt_q;

endmodule
